// File: rtl/spi_burst_controller_if.sv
// Signal bundle between the SPI slave deserialiser, the burst controller
// and the internal register bus.
interface spi_burst_controller_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] i_spi_data_rx;
  logic                  i_spi_ready;
  logic                  i_spi_busy;
  logic                  i_spi_cs_n;
  logic [DATA_WIDTH-1:0] o_spi_data_tx;
  logic [DATA_WIDTH-1:0] i_data_read_bus;
  logic [ADDR_WIDTH-1:0] o_addr_bus;
  logic [DATA_WIDTH-1:0] o_data_write_bus;
  logic                  o_wr_enable_bus;
  logic                  o_rd_enable_bus;
  logic                  o_err;

  modport master (
    input  i_spi_data_rx, i_spi_ready, i_spi_busy, i_spi_cs_n, i_data_read_bus,
    output o_spi_data_tx, o_addr_bus, o_data_write_bus,
           o_wr_enable_bus, o_rd_enable_bus, o_err
  );

  modport slave (
    output i_spi_data_rx, i_spi_ready, i_spi_busy, i_spi_cs_n, i_data_read_bus,
    input  o_spi_data_tx, o_addr_bus, o_data_write_bus,
           o_wr_enable_bus, o_rd_enable_bus, o_err
  );
endinterface

// File: rtl/spi_burst_controller.sv
// SPI-to-register-bus bridge: decodes a command word, then runs single or
// auto-incrementing burst reads/writes until chip select ends the frame.
module spi_burst_controller #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] ACK_WORD   = 8'hA5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  spi_burst_controller_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_WAIT   = 3'd1;
  localparam logic [2:0] WR_STROBE = 3'd2;
  localparam logic [2:0] RD_ISSUE  = 3'd3;
  localparam logic [2:0] RD_WAIT   = 3'd4;
  localparam logic [2:0] RD_LOAD   = 3'd5;
  localparam logic [2:0] RD_HOLD   = 3'd6;

  localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  burst_q, burst_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;

    // Frame end overrides everything, including a coincident ready.
    if (state_q != IDLE && bus.i_spi_cs_n) begin
      state_d = IDLE;
      tx_d    = ACK_WORD;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_spi_ready && !bus.i_spi_cs_n) begin
            addr_d  = bus.i_spi_data_rx[ADDR_WIDTH-1:0];
            burst_d = bus.i_spi_data_rx[ADDR_WIDTH+1];
            if (bus.i_spi_data_rx[ADDR_WIDTH]) begin
              state_d = WR_WAIT;
            end else begin
              state_d = RD_ISSUE;
              rd_en_d = 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (bus.i_spi_ready) begin
            wdata_d = bus.i_spi_data_rx;
            wr_en_d = 1'b1;
            state_d = WR_STROBE;
          end
        end
        WR_STROBE: begin
          err_d = bus.i_spi_ready;
          if (burst_q) begin
            addr_d  = addr_q + 1'b1;
            state_d = WR_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
        RD_ISSUE: begin
          err_d   = bus.i_spi_ready;
          cnt_d   = RD_LAT;
          state_d = (RD_LAT == 4'd0) ? RD_LOAD : RD_WAIT;
        end
        // Leave on the cycle the count reaches zero so RD_WAIT lasts exactly
        // RD_LATENCY cycles (skipped entirely when the latency is zero).
        RD_WAIT: begin
          err_d = bus.i_spi_ready;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = RD_LOAD;
          end
        end
        RD_LOAD: begin
          err_d = bus.i_spi_ready;
          if (!bus.i_spi_busy) begin
            tx_d    = bus.i_data_read_bus;
            state_d = RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (bus.i_spi_ready) begin
            tx_d = ACK_WORD;
            if (burst_q) begin
              addr_d  = addr_q + 1'b1;
              rd_en_d = 1'b1;
              state_d = RD_ISSUE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = ACK_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '1;
      wdata_q <= '0;
      tx_q    <= ACK_WORD;
      cnt_q   <= '0;
      burst_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_spi_data_tx    = tx_q;
  assign bus.o_addr_bus       = addr_q;
  assign bus.o_data_write_bus = wdata_q;
  assign bus.o_wr_enable_bus  = wr_en_q;
  assign bus.o_rd_enable_bus  = rd_en_q;
  assign bus.o_err            = err_q;

endmodule

// File: tb/tb_spi_burst_controller.sv
// Directed bench for spi_burst_controller with RD_LATENCY=3 and a small
// read-data table on the bus side.
module tb_spi_burst_controller;

  logic clk = 1'b0;
  logic rst;

  spi_burst_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  spi_burst_controller #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6),
    .RD_LATENCY(3),
    .ACK_WORD  (8'hA5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.o_addr_bus)
      6'h0A:   bus.i_data_read_bus = 8'h77;
      6'h02:   bus.i_data_read_bus = 8'hC2;
      6'h03:   bus.i_data_read_bus = 8'hD3;
      6'h04:   bus.i_data_read_bus = 8'hE4;
      default: bus.i_data_read_bus = 8'h00;
    endcase
  end

  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  always @(negedge clk) begin
    if (bus.o_wr_enable_bus === 1'b1) wr_cnt++;
    if (bus.o_rd_enable_bus === 1'b1) rd_cnt++;
  end

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    bus.i_spi_data_rx = w;
    bus.i_spi_ready   = 1'b1;
    tick();
    bus.i_spi_ready   = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  int unsigned base;

  initial begin
    rst               = 1'b1;
    bus.i_spi_data_rx = 8'h00;
    bus.i_spi_ready   = 1'b0;
    bus.i_spi_busy    = 1'b0;
    bus.i_spi_cs_n    = 1'b1;
    ticks(3);

    chk("rst_addr",  32'(bus.o_addr_bus),       32'h3F);
    chk("rst_wdata", 32'(bus.o_data_write_bus), 32'h00);
    chk("rst_tx",    32'(bus.o_spi_data_tx),    32'hA5);
    chk("rst_wr",    32'(bus.o_wr_enable_bus),  32'h0);
    chk("rst_rd",    32'(bus.o_rd_enable_bus),  32'h0);
    chk("rst_err",   32'(bus.o_err),            32'h0);

    rst = 1'b0;
    tick();
    // Ready while deselected in IDLE is ignored.
    send(8'h45);
    chk("idle_csn_ign", 32'(bus.o_addr_bus), 32'h3F);
    bus.i_spi_cs_n = 1'b0;
    tick();

    // Single write
    base = wr_cnt;
    send(8'h45);
    chk("sw_no_early_wr", 32'(bus.o_wr_enable_bus), 32'h0);
    send(8'h3C);
    chk("sw_wr",   32'(bus.o_wr_enable_bus),  32'h1);
    chk("sw_addr", 32'(bus.o_addr_bus),       32'h05);
    chk("sw_data", 32'(bus.o_data_write_bus), 32'h3C);
    tick();
    chk("sw_wr_drop", 32'(bus.o_wr_enable_bus), 32'h0);
    send(8'h52);
    chk("sw_cmd2_addr", 32'(bus.o_addr_bus), 32'h12);
    chk("sw_cmd2_nowr", 32'(bus.o_wr_enable_bus), 32'h0);
    send(8'h99);
    chk("sw2_wr",   32'(bus.o_wr_enable_bus),  32'h1);
    chk("sw2_data", 32'(bus.o_data_write_bus), 32'h99);
    tick();
    chk("sw_pulses", wr_cnt - base, 32'd2);

    // Burst write with address wrap
    base = wr_cnt;
    send(8'hFE);
    send(8'h11);
    chk("bw0_addr", 32'(bus.o_addr_bus),       32'h3E);
    chk("bw0_data", 32'(bus.o_data_write_bus), 32'h11);
    tick();
    send(8'h22);
    chk("bw1_addr", 32'(bus.o_addr_bus),       32'h3F);
    chk("bw1_data", 32'(bus.o_data_write_bus), 32'h22);
    tick();
    send(8'h33);
    chk("bw2_wrap", 32'(bus.o_addr_bus),       32'h00);
    chk("bw2_data", 32'(bus.o_data_write_bus), 32'h33);
    tick();
    bus.i_spi_cs_n = 1'b1;
    tick();
    bus.i_spi_cs_n = 1'b0;
    ticks(3);
    chk("bw_pulses", wr_cnt - base, 32'd3);

    // Single read, latency 3: ready in T, tx valid at T+6
    base = rd_cnt;
    send(8'h0A);
    chk("sr_rd",   32'(bus.o_rd_enable_bus), 32'h1);
    chk("sr_addr", 32'(bus.o_addr_bus),      32'h0A);
    tick();
    chk("sr_rd_drop", 32'(bus.o_rd_enable_bus), 32'h0);
    ticks(3);
    chk("sr_tx_early", 32'(bus.o_spi_data_tx), 32'hA5);
    tick();
    chk("sr_tx", 32'(bus.o_spi_data_tx), 32'h77);
    ticks(2);
    chk("sr_tx_hold", 32'(bus.o_spi_data_tx), 32'h77);
    send(8'h00);
    chk("sr_tx_ack", 32'(bus.o_spi_data_tx), 32'hA5);
    chk("sr_pulses", rd_cnt - base, 32'd1);

    // Burst read with an early ready inside RD_WAIT
    send(8'h82);
    chk("br0_rd",   32'(bus.o_rd_enable_bus), 32'h1);
    chk("br0_addr", 32'(bus.o_addr_bus),      32'h02);
    tick();
    send(8'hFF);
    chk("br_err", 32'(bus.o_err), 32'h1);
    tick();
    chk("br_err_drop", 32'(bus.o_err), 32'h0);
    tick();
    chk("br0_tx_early", 32'(bus.o_spi_data_tx), 32'hA5);
    tick();
    chk("br0_tx", 32'(bus.o_spi_data_tx), 32'hC2);
    send(8'h00);
    chk("br1_addr", 32'(bus.o_addr_bus),      32'h03);
    chk("br1_rd",   32'(bus.o_rd_enable_bus), 32'h1);
    chk("br1_ack",  32'(bus.o_spi_data_tx),   32'hA5);
    ticks(5);
    chk("br1_tx", 32'(bus.o_spi_data_tx), 32'hD3);
    send(8'h00);
    chk("br2_addr", 32'(bus.o_addr_bus), 32'h04);
    ticks(5);
    chk("br2_tx", 32'(bus.o_spi_data_tx), 32'hE4);
    bus.i_spi_cs_n = 1'b1;
    tick();
    chk("br_abort_tx", 32'(bus.o_spi_data_tx), 32'hA5);
    bus.i_spi_cs_n = 1'b0;
    tick();

    // Busy held across RD_LOAD defers the capture
    send(8'h0A);
    tick();
    bus.i_spi_busy = 1'b1;
    ticks(4);
    chk("busy_defer", 32'(bus.o_spi_data_tx), 32'hA5);
    bus.i_spi_busy = 1'b0;
    tick();
    chk("busy_load", 32'(bus.o_spi_data_tx), 32'h77);
    send(8'h00);
    chk("busy_ack", 32'(bus.o_spi_data_tx), 32'hA5);

    // Abort in WR_WAIT of a burst, with a coincident ready
    base = wr_cnt;
    send(8'hC1);
    send(8'h5A);
    chk("ab_wr",   32'(bus.o_wr_enable_bus), 32'h1);
    chk("ab_addr", 32'(bus.o_addr_bus),      32'h01);
    tick();
    bus.i_spi_cs_n = 1'b1;
    send(8'h6B);
    chk("ab_no_err", 32'(bus.o_err),           32'h0);
    chk("ab_no_wr",  32'(bus.o_wr_enable_bus), 32'h0);
    chk("ab_tx",     32'(bus.o_spi_data_tx),   32'hA5);
    bus.i_spi_cs_n = 1'b0;
    ticks(3);
    chk("ab_keep_addr", 32'(bus.o_addr_bus),       32'h02);
    chk("ab_keep_data", 32'(bus.o_data_write_bus), 32'h5A);
    chk("ab_pulses",    wr_cnt - base,             32'd1);

    // Reset mid RD_WAIT
    base = rd_cnt;
    send(8'h0A);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_addr",  32'(bus.o_addr_bus),       32'h3F);
    chk("mr_wdata", 32'(bus.o_data_write_bus), 32'h00);
    chk("mr_tx",    32'(bus.o_spi_data_tx),    32'hA5);
    chk("mr_rd",    32'(bus.o_rd_enable_bus),  32'h0);
    ticks(5);
    chk("mr_tx_idle", 32'(bus.o_spi_data_tx), 32'hA5);
    chk("mr_pulses",  rd_cnt - base,          32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
